// File: rtl/id_ex_pipe_pkg.sv
`default_nettype none
// ============================================================================
// id_ex_pipe_pkg : shared widths, ALU op encodings and bubble field values
// Revision: 1.0
// ============================================================================
package id_ex_pipe_pkg;

  localparam int N_DEF = 16;
  localparam int C_DEF = 4;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_ROL   = 4'd8,
    ALU_ROR   = 4'd9,
    ALU_SLT   = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_e;

  // Control group packing: {valid, wr_en, mem_rd, mem_wr, halt}
  localparam logic [4:0] BUBBLE_CTRL   = 5'b0_0000;
  localparam logic [3:0] BUBBLE_ALU_OP = ALU_ADD;
  localparam logic [2:0] BUBBLE_WR_REG = 3'd0;

  function automatic logic [4:0] gate_ctrl(input logic valid, input logic wr_en,
                                           input logic mem_rd, input logic mem_wr,
                                           input logic halt);
    return {valid, wr_en & valid, mem_rd & valid, mem_wr & valid, halt & valid};
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_if.sv
`default_nettype none
// ============================================================================
// id_ex_pipe_if : decode-side inputs and execute-side registered outputs
// Revision: 1.0
// ============================================================================
interface id_ex_pipe_if #(
  parameter int N = id_ex_pipe_pkg::N_DEF,
  parameter int C = id_ex_pipe_pkg::C_DEF
);
  logic         stall;
  logic         flush;
  logic         id_valid;
  logic [N-1:0] id_rs_data;
  logic [N-1:0] id_rt_data;
  logic [N-1:0] id_imm;
  logic [N-1:0] id_pc_plus2;
  logic         id_use_imm;
  logic [3:0]   id_alu_op;
  logic         id_wr_en;
  logic         id_mem_rd;
  logic         id_mem_wr;
  logic         id_halt;
  logic [2:0]   id_wr_reg;

  logic         ex_valid;
  logic         ex_wr_en;
  logic         ex_mem_rd;
  logic         ex_mem_wr;
  logic         ex_halt;
  logic [N-1:0] ex_a;
  logic [N-1:0] ex_b;
  logic [N-1:0] ex_pc_plus2;
  logic [C-1:0] ex_shamt;
  logic [3:0]   ex_alu_op;
  logic [2:0]   ex_wr_reg;
  logic         halted;
  logic [N-1:0] stall_cycles;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_pc_plus2,
           id_use_imm, id_alu_op, id_wr_en, id_mem_rd, id_mem_wr, id_halt, id_wr_reg,
    input  ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_halt, ex_a, ex_b,
           ex_pc_plus2, ex_shamt, ex_alu_op, ex_wr_reg, halted, stall_cycles
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_pc_plus2,
           id_use_imm, id_alu_op, id_wr_en, id_mem_rd, id_mem_wr, id_halt, id_wr_reg,
    output ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_halt, ex_a, ex_b,
           ex_pc_plus2, ex_shamt, ex_alu_op, ex_wr_reg, halted, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_pipe_pipe_reg.sv
`default_nettype none
// ============================================================================
// pipe_reg : enabled register with synchronous clear to a bubble value
// Revision: 1.0
// ============================================================================
module pipe_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         en_i,
  input  wire logic         clr_i,
  input  wire logic [W-1:0] d_i,
  output logic      [W-1:0] q_o
);

  // Clear outranks enable so a flush or halt bubble wins over a stall hold.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      q_o <= CLR_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// id_ex_pipe : decode-to-execute pipeline register with stall/flush/halt
// Revision: 1.0
// ============================================================================
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int C = C_DEF
) (
  input wire logic    clk,
  input wire logic    rst,
  id_ex_pipe_if.slave bus
);

  logic           load_en;
  logic           load_clr;
  logic [N-1:0]   b_sel;
  logic [4:0]     ctrl_d, ctrl_q;
  logic [3*N-1:0] data_d, data_q;
  logic [C-1:0]   shamt_q;
  logic [6:0]     op_q;
  logic           halted_q, halted_d;
  logic [N-1:0]   stall_cnt_q, stall_cnt_d;

  assign b_sel    = bus.id_use_imm ? bus.id_imm : bus.id_rt_data;
  assign load_en  = ~bus.stall;
  // An invalid decode entry loads as a bubble, same as flush or halt.
  assign load_clr = halted_q | bus.flush | (~bus.stall & ~bus.id_valid);

  assign ctrl_d = gate_ctrl(bus.id_valid, bus.id_wr_en, bus.id_mem_rd,
                            bus.id_mem_wr, bus.id_halt);
  assign data_d = {bus.id_rs_data, b_sel, bus.id_pc_plus2};

  pipe_reg #(.W(5), .CLR_VAL(BUBBLE_CTRL)) u_ctrl (
    .clk(clk), .rst(rst), .en_i(load_en), .clr_i(load_clr), .d_i(ctrl_d), .q_o(ctrl_q)
  );

  pipe_reg #(.W(3*N), .CLR_VAL('0)) u_data (
    .clk(clk), .rst(rst), .en_i(load_en), .clr_i(load_clr), .d_i(data_d), .q_o(data_q)
  );

  pipe_reg #(.W(C), .CLR_VAL('0)) u_shamt (
    .clk(clk), .rst(rst), .en_i(load_en), .clr_i(load_clr), .d_i(b_sel[C-1:0]), .q_o(shamt_q)
  );

  pipe_reg #(.W(7), .CLR_VAL({BUBBLE_ALU_OP, BUBBLE_WR_REG})) u_op (
    .clk(clk), .rst(rst), .en_i(load_en), .clr_i(load_clr),
    .d_i({bus.id_alu_op, bus.id_wr_reg}), .q_o(op_q)
  );

  always_comb begin
    halted_d    = halted_q;
    stall_cnt_d = stall_cnt_q;
    if (!halted_q && ctrl_q[4] && ctrl_q[0] && !bus.stall && !bus.flush) begin
      halted_d = 1'b1;
    end
    if (!halted_q && ctrl_q[4] && bus.stall && !bus.flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {bus.ex_valid, bus.ex_wr_en, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_halt} = ctrl_q;
  assign {bus.ex_a, bus.ex_b, bus.ex_pc_plus2} = data_q;
  assign bus.ex_shamt     = shamt_q;
  assign {bus.ex_alu_op, bus.ex_wr_reg} = op_q;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// tb_id_ex_pipe : directed + short random stimulus against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_id_ex_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_pipe_if #(.N(16), .C(4)) bus ();
  id_ex_pipe #(.N(16), .C(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic v, wr, rd, mw, h;
    logic [15:0] a, b, pc;
    logic [3:0] sh, op;
    logic [2:0] wreg;
  } ent_t;

  ent_t        m_ent, m_nxt, act;
  logic        m_halted, set_h;
  logic [15:0] m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_on  = 1'b0;
  int          cyc     = 0;

  // Reference: what the execute stage must hold after each edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ent = '0; m_halted = 1'b0; m_cnt = 16'd0;
    end else begin
      set_h = !m_halted && m_ent.v && m_ent.h && !bus.stall && !bus.flush;
      if (m_halted || bus.flush) begin
        m_ent = '0;
      end else if (bus.stall) begin
        if (m_ent.v && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (!bus.id_valid) begin
        m_ent = '0;
      end else begin
        m_nxt.v    = 1'b1;
        m_nxt.wr   = bus.id_wr_en;
        m_nxt.rd   = bus.id_mem_rd;
        m_nxt.mw   = bus.id_mem_wr;
        m_nxt.h    = bus.id_halt;
        m_nxt.a    = bus.id_rs_data;
        m_nxt.b    = bus.id_use_imm ? bus.id_imm : bus.id_rt_data;
        m_nxt.pc   = bus.id_pc_plus2;
        m_nxt.sh   = m_nxt.b[3:0];
        m_nxt.op   = bus.id_alu_op;
        m_nxt.wreg = bus.id_wr_reg;
        m_ent      = m_nxt;
      end
      if (set_h) m_halted = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      act = {bus.ex_valid, bus.ex_wr_en, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_halt,
             bus.ex_a, bus.ex_b, bus.ex_pc_plus2, bus.ex_shamt, bus.ex_alu_op, bus.ex_wr_reg};
      n_tests++;
      if (act !== m_ent || bus.halted !== m_halted || bus.stall_cycles !== m_cnt) begin
        n_fail++;
        $display("FAIL model_cmp cyc=%0d ex=%h halted=%b cnt=%h | required ex=%h halted=%b cnt=%h",
                 cyc, act, bus.halted, bus.stall_cycles, m_ent, m_halted, m_cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] rs, input logic [15:0] rt,
                       input logic [15:0] imm, input logic [15:0] pc, input logic ui,
                       input logic [3:0] op, input logic we, input logic mrd,
                       input logic mwr, input logic h, input logic [2:0] wreg);
    bus.id_valid = v;   bus.id_rs_data = rs; bus.id_rt_data = rt; bus.id_imm = imm;
    bus.id_pc_plus2 = pc; bus.id_use_imm = ui; bus.id_alu_op = op; bus.id_wr_en = we;
    bus.id_mem_rd = mrd; bus.id_mem_wr = mwr; bus.id_halt = h; bus.id_wr_reg = wreg;
  endtask

  initial begin
    bus.stall = 1'b1; bus.flush = 1'b0;
    drive(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 4'hF, 1, 1, 1, 1, 3'd7);
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_ex_a", {16'd0, bus.ex_a}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_stall_cycles", {16'd0, bus.stall_cycles}, 32'd0);

    rst = 1'b0; bus.stall = 1'b0;
    drive(1, 16'h1234, 16'hBEEF, 16'h0003, 16'h0102, 1, 4'd5, 1, 0, 0, 0, 3'd2);
    tick();
    chk("imm_ex_a", {16'd0, bus.ex_a}, 32'h1234);
    chk("imm_ex_b", {16'd0, bus.ex_b}, 32'h0003);
    chk("imm_ex_shamt", {28'd0, bus.ex_shamt}, 32'd3);
    chk("imm_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("imm_ex_wr_en", {31'd0, bus.ex_wr_en}, 32'd1);
    chk("imm_ex_pc", {16'd0, bus.ex_pc_plus2}, 32'h0102);
    chk("imm_ex_op", {28'd0, bus.ex_alu_op}, 32'd5);
    chk("imm_ex_wr_reg", {29'd0, bus.ex_wr_reg}, 32'd2);

    bus.id_use_imm = 1'b0;
    tick();
    chk("rt_ex_b", {16'd0, bus.ex_b}, 32'hBEEF);
    chk("rt_ex_shamt", {28'd0, bus.ex_shamt}, 32'hF);

    drive(0, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 0, 4'd3, 1, 1, 1, 0, 3'd4);
    tick();
    chk("inv_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("inv_ex_wr_en", {31'd0, bus.ex_wr_en}, 32'd0);
    chk("inv_ex_mem_rd", {31'd0, bus.ex_mem_rd}, 32'd0);
    chk("inv_ex_a", {16'd0, bus.ex_a}, 32'd0);

    drive(1, 16'hA5A5, 16'h0F0F, 16'h0011, 16'h0200, 0, 4'd1, 0, 1, 0, 0, 3'd7);
    tick();
    bus.stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.id_rs_data = 16'(i * 16'h1111); bus.id_rt_data = 16'(i);
      tick();
      chk("stall_hold_ex_a", {16'd0, bus.ex_a}, 32'hA5A5);
      chk("stall_hold_ex_b", {16'd0, bus.ex_b}, 32'h0F0F);
    end
    chk("stall_cycles_3", {16'd0, bus.stall_cycles}, 32'd3);

    bus.flush = 1'b1;
    drive(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 4'd2, 1, 0, 0, 0, 3'd1);
    tick();
    chk("flush_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_ex_wr_en", {31'd0, bus.ex_wr_en}, 32'd0);
    chk("flush_stall_cycles", {16'd0, bus.stall_cycles}, 32'd3);
    bus.flush = 1'b0;
    tick();
    chk("bubble_stall_nocount", {16'd0, bus.stall_cycles}, 32'd3);

    bus.stall = 1'b0;
    drive(1, 16'h0BAD, 16'h0001, 16'h0002, 16'h0300, 0, 4'd0, 0, 0, 0, 1, 3'd0);
    tick();
    bus.id_valid = 1'b0;
    tick();
    chk("halt_set", {31'd0, bus.halted}, 32'd1);
    drive(1, 16'h1357, 16'h2468, 16'h0001, 16'h0400, 0, 4'd4, 1, 0, 0, 0, 3'd3);
    tick();
    chk("halted_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    chk("halted_sticky", {31'd0, bus.halted}, 32'd1);
    chk("halted_no_count", {16'd0, bus.stall_cycles}, 32'd3);

    // Halt entry followed by a valid entry: halted and ex_valid both high.
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    tick();
    rst = 1'b0;
    drive(1, 16'h0C0C, 16'h0001, 16'h0002, 16'h0500, 0, 4'd0, 0, 0, 0, 1, 3'd0);
    tick();
    drive(1, 16'h7777, 16'h0001, 16'h0002, 16'h0502, 0, 4'd6, 1, 0, 0, 0, 3'd5);
    tick();
    chk("halt2_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt2_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    bus.stall = 1'b1; rst = 1'b1;
    tick();
    chk("rst_mid_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_mid_ex_a", {16'd0, bus.ex_a}, 32'd0);
    chk("rst_mid_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_mid_cnt", {16'd0, bus.stall_cycles}, 32'd0);
    rst = 1'b0; bus.stall = 1'b0;
    drive(1, 16'h4242, 16'h0009, 16'h0000, 16'h0600, 0, 4'd7, 1, 0, 0, 0, 3'd6);
    tick();
    chk("post_rst_ex_a", {16'd0, bus.ex_a}, 32'h4242);
    chk("post_rst_ex_valid", {31'd0, bus.ex_valid}, 32'd1);

    for (int i = 0; i < 80; i++) begin
      rst       = ($urandom_range(0, 29) == 0);
      bus.flush = ($urandom_range(0, 5) == 0);
      bus.stall = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 9) == 0), 3'($urandom));
      tick();
    end

    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    tick();
    rst = 1'b0;
    drive(1, 16'h00AA, 16'h0001, 16'h0000, 16'h0700, 0, 4'd0, 0, 0, 0, 0, 3'd1);
    tick();
    bus.stall = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe", {16'd0, bus.stall_cycles}, 32'hFFFE);
    repeat (3) tick();
    chk("sat_ffff", {16'd0, bus.stall_cycles}, 32'hFFFF);
    chk("sat_hold_ex_a", {16'd0, bus.ex_a}, 32'h00AA);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter N, default 16, datapath width.
REQ-002 Parameter C, default 4, shift-count width delivered to the execute-stage rotator/shifter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  hold current entry.
REQ-007 flush  in  1  replace entry with bubble.
REQ-008 id_valid  in  1  decode entry is a real instruction.
REQ-009 id_rs_data, id_rt_data, id_imm, id_pc_plus2  in  N each  decode operands / immediate / PC+2.
REQ-010 id_use_imm  in  1  B operand = immediate.
REQ-011 id_alu_op  in  4  ALU/shift op code (package enum).
REQ-012 id_wr_en, id_mem_rd, id_mem_wr, id_halt  in  1 each  side-effect controls.
REQ-013 id_wr_reg  in  3  destination register.
REQ-014 ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_halt  out  1 each  registered controls.
REQ-015 ex_a, ex_b, ex_pc_plus2  out  N each  registered operands; ex_b already immediate-selected.
REQ-016 ex_shamt  out  C  registered, equal to ex_b[C-1:0].
REQ-017 ex_alu_op  out  4; ex_wr_reg  out  3.
REQ-018 halted  out  1  sticky halt indicator; stall_cycles  out  N  saturating stall counter.

Function
REQ-019 Per-edge priority SHALL be: rst > halted > flush > stall > load.
REQ-020 Load: all ex_* fields SHALL capture decode inputs at the rising edge; latency exactly 1 cycle.
REQ-021 ex_b SHALL capture id_imm when id_use_imm=1, else id_rt_data; ex_shamt captures the same selected value's low C bits.
REQ-022 Load with id_valid=0 SHALL produce a bubble.
REQ-023 Bubble: ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_halt = 0; all data fields, ex_alu_op, ex_wr_reg = 0.
REQ-024 Stored side-effect controls SHALL be AND-gated with valid at capture; never 1 while ex_valid=0.
REQ-025 stall=1, flush=0: every ex_* output SHALL hold its value.
REQ-026 flush=1 SHALL load a bubble regardless of stall or id_valid.
REQ-027 halted SHALL set at an edge where ex_valid=1, ex_halt=1, stall=0, flush=0; clears only on rst.
REQ-028 halted=1: stage SHALL load bubbles every cycle, ignoring all id_* inputs, stall and flush.
REQ-029 stall_cycles SHALL increment at each edge with stall=1, flush=0, ex_valid=1, halted=0; saturates at all-ones (no wrap).
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 On rst=1 at a rising edge: all outputs 0 (bubble), halted=0, stall_cycles=0, regardless of other inputs.
REQ-032 rst mid-stall or mid-halt SHALL discard the held entry; first edge after rst deasserts behaves as normal load.

Structure
REQ-033 Shared package SHALL hold N, C defaults, alu_op encodings, and bubble field constants.
REQ-034 One sub-module pipe_reg (parameterized width, enable, synchronous clear) SHALL implement each stored field group.
REQ-035 Output fields SHALL be driven directly from flops.

Verification
REQ-036 Load rs=0x1234, imm=0x0003, use_imm=1, valid=1 -> next cycle ex_a=0x1234, ex_b=0x0003, ex_shamt=3, ex_valid=1.
REQ-037 Load entry, then stall=1 for 3 cycles with changing id_* -> ex_* unchanged 3 cycles; stall_cycles=3.
REQ-038 stall=1 and flush=1 same cycle, wr_en=1 -> bubble: ex_valid=0, ex_wr_en=0, stall_cycles unchanged.
REQ-039 Valid halt entry advances -> halted=1 next edge; following valid loads yield ex_valid=0 until rst.
REQ-040 Force stall_cycles to 0xFFFE (or 65534 stalls) then 3 more stalls -> holds 0xFFFF.
REQ-041 rst asserted during stall with ex_valid=1, halted=1 -> next cycle all outputs 0, halted=0, stall_cycles=0.
